button_event_ctrl: RTL and testbench
====================================

# button_event_ctrl

Sequencer that sits downstream of a debounced button level and turns it into discrete user-interface events. It emits a one-cycle press pulse, a one-cycle release pulse and a one-cycle long-press pulse after a programmable hold time. Optionally, it emits auto-repeat pulses while the button stays held. It is the single place where hold-time policy lives, so front-panel logic consumes events rather than raw levels.

## Interface
- LONG_CNT, default 8: clock cycles of continuous hold after the press edge before `longOut`; legal range ≥ 1.
- REPEAT_CNT, default 4: clock cycles between successive `repeatOut` pulses once long-press is reached; legal range ≥ 1.
- CNT_W, default 16: hold counter width; must satisfy 2^CNT_W > max(LONG_CNT, REPEAT_CNT).
- clkIn  input  1  single clock; all logic is rising-edge.
- rstIn  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronous to clkIn upstream.
- enIn  input  1  block enable; when low, the FSM is held in IDLE and all pulses are 0.
- buttonIn  input  1  debounced button level, synchronous to clkIn; 1 = pressed.
- pressOut  output  1  one-cycle pulse on a press.
- releaseOut  output  1  one-cycle pulse on a release.
- longOut  output  1  one-cycle pulse when the hold reaches LONG_CNT.
- repeatOut  output  1  one-cycle pulse every REPEAT_CNT cycles while in LONG.
- heldOut  output  1  level; 1 while the FSM is in DOWN or LONG.
- stateOut  output  2  current state encoding: IDLE=00, DOWN=01, LONG=10.

## Operation
- Three-state FSM with a CNT_W-bit counter `cnt`. All outputs are registered. Pulses default to 0 every cycle.
- **IDLE:** if enIn & buttonIn, go to DOWN, set cnt←0 and pressOut←1. Otherwise stay.
- **DOWN:**
  - If !buttonIn, go to IDLE and set releaseOut←1.
  - Else if cnt == LONG_CNT-1, go to LONG, set cnt←0 and longOut←1.
  - Else cnt←cnt+1.
- **LONG:**
  - If !buttonIn, go to IDLE and set releaseOut←1.
  - Else if cnt == REPEAT_CNT-1, set cnt←0 and repeatOut←1.
  - Else cnt←cnt+1.
- **Release priority:** release is checked before the count compare. A release on the same edge the count would expire gives releaseOut only, with no longOut or repeatOut.
- **enIn low:** from any state, the next edge forces IDLE with cnt←0 and no pulses, including no releaseOut. While enIn is low, buttonIn is ignored.
- **Re-press:** re-entering IDLE→DOWN requires buttonIn high while in IDLE. A button held through an enIn low→high transition produces pressOut on the first enabled edge.
- heldOut = (state != IDLE). stateOut mirrors the state register.
- The counter never wraps: it is cleared before reaching its compare value + 1.

## Timing
- **Reset:** state=IDLE, cnt=0. pressOut, releaseOut, longOut, repeatOut and heldOut are 0; stateOut=00.
- **Reset mid-hold:** returns to IDLE immediately, with no release pulse.
- **Press latency:** buttonIn sampled high at edge E0 in IDLE → pressOut and heldOut high after E0. pressOut lasts exactly one cycle.
- **Long:** longOut is high for the cycle after edge E0+LONG_CNT, provided buttonIn was high at every edge E0..E0+LONG_CNT.
- **Repeat:** repeatOut is high after edges E0+LONG_CNT+k·REPEAT_CNT, for k ≥ 1.
- **Release latency:** buttonIn sampled low at edge Er → releaseOut high and heldOut low after Er.
- **Minimum press:** buttonIn high for one sample then low gives pressOut at E0 and releaseOut at E0+1, back to back.
- **Exclusivity:** at most one of the four pulse outputs is high in any cycle.

## Configuration
- Macro: BUTTON_EVENT_REPEAT_EN.
- **Defined:** LONG-state repeat counting and repeatOut behave as above.
- **Undefined:**
  - repeatOut is tied to 0.
  - In LONG, cnt holds at 0 and the FSM stays in LONG until release.
  - The REPEAT_CNT parameter is accepted and ignored.

## Test plan
- **Short tap** (LONG_CNT=8): reset, buttonIn high for 3 cycles then low → pressOut 1 cycle after the first high edge, releaseOut 1 cycle after the first low edge; longOut never asserts; heldOut high for exactly 3 cycles.
- **Long hold with repeat** (LONG_CNT=8, REPEAT_CNT=4, macro defined): hold 20 cycles from E0 → longOut at E0+8; repeatOut at E0+12, E0+16 and E0+20; releaseOut on the first low sample.
- **Release at boundary:** buttonIn falls exactly at E0+8 → releaseOut only, no longOut; state returns to 00.
- **Macro undefined:** same 20-cycle hold → longOut at E0+8; repeatOut stays 0; stateOut=10 until release.
- **Async reset mid-hold:** drive rstIn low asynchronously while in LONG → all outputs 0 and stateOut=00 immediately; no releaseOut after reset deassertion.
- **Enable gating:** enIn low while in DOWN → IDLE on the next edge with no pulses. Raising enIn with the button still held → pressOut on the first enabled edge.

Source files
------------

// File: rtl/button_event_ctrl_if.sv
// Button event bus: enable/level in, event pulses and state out.
// The master side drives the level inputs; the slave side is the controller.
interface button_event_ctrl_if;
  logic       enIn;
  logic       buttonIn;
  logic       pressOut;
  logic       releaseOut;
  logic       longOut;
  logic       repeatOut;
  logic       heldOut;
  logic [1:0] stateOut;

  modport master (
    output enIn,
    output buttonIn,
    input  pressOut,
    input  releaseOut,
    input  longOut,
    input  repeatOut,
    input  heldOut,
    input  stateOut
  );

  modport slave (
    input  enIn,
    input  buttonIn,
    output pressOut,
    output releaseOut,
    output longOut,
    output repeatOut,
    output heldOut,
    output stateOut
  );
endinterface

// File: rtl/button_event_ctrl.sv
// Turns a debounced button level into press/release/long-press/auto-repeat pulses.
// Auto-repeat is built only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event_ctrl #(
  parameter int unsigned LONG_CNT   = 8,
  parameter int unsigned REPEAT_CNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clkIn,
  input  logic                rstIn,
  button_event_ctrl_if.slave  bus
);

  localparam int unsigned MaxCnt = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;

  if ((LONG_CNT < 1) || (REPEAT_CNT < 1) ||
      ((CNT_W < 32) && ((64'd1 << CNT_W) <= 64'(MaxCnt)))) begin : g_param_check
    $error("button_event_ctrl: illegal LONG_CNT/REPEAT_CNT/CNT_W combination");
  end

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StDown = 2'b01,
    StLong = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CNT - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CNT - 1);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    if (!bus.enIn) begin
      // Disable is silent: no release pulse even if the button was held.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.buttonIn) begin
            state_d = StDown;
            cnt_d   = '0;
            press_d = 1'b1;
          end
        end
        StDown: begin
          // Release wins over an expiring count.
          if (!bus.buttonIn) begin
            state_d   = StIdle;
            cnt_d     = '0;
            release_d = 1'b1;
          end else if (cnt_q == LongLast) begin
            state_d = StLong;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StLong: begin
          if (!bus.buttonIn) begin
            state_d   = StIdle;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
            if (cnt_q == RepeatLast) begin
              cnt_d    = '0;
              repeat_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`else
            cnt_d = '0;
`endif
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    held_d = (state_d != StIdle);
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign bus.pressOut   = press_q;
  assign bus.releaseOut = release_q;
  assign bus.longOut    = long_q;
  assign bus.repeatOut  = repeat_q;
  assign bus.heldOut    = held_q;
  assign bus.stateOut   = state_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl (LONG_CNT=8, REPEAT_CNT=4).
// Output vector order: {stateOut[1:0], heldOut, repeatOut, longOut, releaseOut, pressOut}.
module tb_button_event_ctrl;

  localparam logic [6:0] VIdle  = 7'b00_0_0000;
  localparam logic [6:0] VPress = 7'b01_1_0001;
  localparam logic [6:0] VDown  = 7'b01_1_0000;
  localparam logic [6:0] VRel   = 7'b00_0_0010;
  localparam logic [6:0] VLongP = 7'b10_1_0100;
  localparam logic [6:0] VLong  = 7'b10_1_0000;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [6:0] VRep   = 7'b10_1_1000;
`else
  localparam logic [6:0] VRep   = 7'b10_1_0000;
`endif

  logic clkIn = 1'b0;
  logic rstIn;
  int   errors = 0;
  int   checks = 0;

  button_event_ctrl_if bus ();

  button_event_ctrl #(
    .LONG_CNT   (8),
    .REPEAT_CNT (4),
    .CNT_W      (16)
  ) dut (
    .clkIn (clkIn),
    .rstIn (rstIn),
    .bus   (bus.slave)
  );

  always #5 clkIn = ~clkIn;

  function automatic logic [6:0] outs();
    return {bus.stateOut, bus.heldOut, bus.repeatOut, bus.longOut, bus.releaseOut, bus.pressOut};
  endfunction

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rstIn        = 1'b1;
    bus.enIn     = 1'b1;
    bus.buttonIn = 1'b0;
    #1 rstIn = 1'b0;
    #1 chk("reset_async", VIdle);
    tick();
    tick();
    chk("reset_held", VIdle);
    rstIn = 1'b1;
    tick();
    chk("reset_release", VIdle);

    // Short tap: three high samples.
    bus.buttonIn = 1'b1;
    tick(); chk("tap_press", VPress);
    tick(); chk("tap_down1", VDown);
    tick(); chk("tap_down2", VDown);
    bus.buttonIn = 1'b0;
    tick(); chk("tap_release", VRel);
    tick(); chk("tap_idle", VIdle);

    // Long hold, high at E0..E0+20.
    bus.buttonIn = 1'b1;
    tick(); chk("hold_press", VPress);
    for (int i = 1; i <= 7; i++) begin
      tick(); chk("hold_down", VDown);
    end
    tick(); chk("hold_long", VLongP);
    for (int i = 9; i <= 20; i++) begin
      tick();
      if (i % 4 == 0) chk("hold_repeat", VRep);
      else            chk("hold_long_lvl", VLong);
    end
    bus.buttonIn = 1'b0;
    tick(); chk("hold_release", VRel);
    tick(); chk("hold_idle", VIdle);

    // Release exactly when the long count would expire.
    bus.buttonIn = 1'b1;
    tick(); chk("bnd_press", VPress);
    for (int i = 1; i <= 7; i++) begin
      tick(); chk("bnd_down", VDown);
    end
    bus.buttonIn = 1'b0;
    tick(); chk("bnd_release_only", VRel);
    tick(); chk("bnd_idle", VIdle);

    // Asynchronous reset while in LONG.
    bus.buttonIn = 1'b1;
    tick(); chk("rst_press", VPress);
    for (int i = 1; i <= 8; i++) tick();
    chk("rst_in_long", VLongP);
    tick(); chk("rst_long_lvl", VLong);
    #2 rstIn = 1'b0;
    #1 chk("rst_mid_hold", VIdle);
    tick(); chk("rst_mid_hold_edge", VIdle);
    bus.buttonIn = 1'b0;
    rstIn        = 1'b1;
    tick(); chk("rst_no_release", VIdle);
    tick(); chk("rst_no_release2", VIdle);

    // Enable gating while in DOWN, button kept high.
    bus.buttonIn = 1'b1;
    tick(); chk("en_press", VPress);
    tick(); chk("en_down", VDown);
    bus.enIn = 1'b0;
    tick(); chk("en_off_idle", VIdle);
    tick(); chk("en_off_ignore", VIdle);
    bus.enIn = 1'b1;
    tick(); chk("en_on_press", VPress);
    tick(); chk("en_on_down", VDown);
    bus.buttonIn = 1'b0;
    tick(); chk("en_release", VRel);

    // Minimum press: one high sample.
    bus.buttonIn = 1'b1;
    tick(); chk("min_press", VPress);
    bus.buttonIn = 1'b0;
    tick(); chk("min_release", VRel);
    tick(); chk("min_idle", VIdle);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
